// File: rtl/piso_tx.sv
// piso_tx: parallel-in, serial-out shift transmitter.
// Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out on
// s_out, one bit every DIV clocks, using a clock-enable divider.
// Optional even-parity trailer bit: define PISO_TX_PARITY_EN.
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             s_out,
    output logic             busy,
    output logic             done
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_shift;
    logic [DW-1:0]    div_cnt;
    logic [BW-1:0]    bit_cnt;
    logic             bit_end, last_bit;
`ifdef PISO_TX_PARITY_EN
    logic             par_bit;
`endif

    // Bit that goes on the wire first out of a given word.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign bit_end    = (div_cnt == DIV_LAST);
    assign last_bit   = bit_end && (bit_cnt == BIT_LAST);
    assign sreg_shift = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: frame advances only at bit boundaries.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (load_valid) state_nxt = SHIFT;
`ifdef PISO_TX_PARITY_EN
            SHIFT:  if (last_bit) state_nxt = PARITY;
            PARITY: if (bit_end)  state_nxt = IDLE;
`else
            SHIFT: if (last_bit) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake output decoded straight from the state register.
    always_comb begin
        load_ready = (state == IDLE);
    end

    // Datapath: shift register, divider, bit counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg    <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            s_out   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            busy <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    s_out <= 1'b0;
                    if (load_valid) begin
                        sreg    <= data_in;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        // First bit is launched at the accept edge so it is on
                        // the wire in the very next cycle.
                        s_out   <= first_bit(data_in);
`ifdef PISO_TX_PARITY_EN
                        par_bit <= ^data_in;
`endif
                    end
                end
                SHIFT: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        sreg    <= sreg_shift;
                        if (bit_cnt == BIT_LAST) begin
                            // Counter returns to 0 rather than overflowing.
                            bit_cnt <= '0;
`ifdef PISO_TX_PARITY_EN
                            s_out   <= par_bit;
`else
                            s_out   <= 1'b0;
                            done    <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            s_out   <= first_bit(sreg_shift);
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
`ifdef PISO_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        s_out   <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
`endif
                default: s_out <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed, table-driven bench for piso_tx.
// Instance a: WIDTH=8, DIV=4, MSB first.  Instance b: WIDTH=8, DIV=1, LSB first.
`timescale 1ns/1ps
module tb_piso_tx;

`ifdef PISO_TX_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] din_a = '0, din_b = '0;
    logic       lv_a = 1'b0, lv_b = 1'b0;
    logic       lr_a, so_a, bz_a, dn_a;
    logic       lr_b, so_b, bz_b, dn_b;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .reset(reset), .data_in(din_a), .load_valid(lv_a),
        .load_ready(lr_a), .s_out(so_a), .busy(bz_a), .done(dn_a));

    piso_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset), .data_in(din_b), .load_valid(lv_b),
        .load_ready(lr_b), .s_out(so_b), .busy(bz_b), .done(dn_b));

    // seq holds the expected wire order: seq[7] is the first bit transmitted.
    typedef struct {
        bit         sel;
        logic [7:0] word;
        logic [7:0] seq;
        logic       par;
        string      tag;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string tag, input string what, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s %s: got %0h expected %0h at %0t", tag, what, act, exp, $time);
        end
    endtask

    // {load_ready, s_out, busy, done} of the selected instance.
    function automatic logic [3:0] outs(input bit sel);
        return sel ? {lr_b, so_b, bz_b, dn_b} : {lr_a, so_a, bz_a, dn_a};
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin lv_b = v; din_b = d; end
        else     begin lv_a = v; din_a = d; end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word for one accept edge; afterwards scramble data_in.
    task automatic start(input bit sel, input logic [7:0] w);
        drive(sel, 1'b1, w);
        tick();
        drive(sel, 1'b0, ~w);
    endtask

    // Check every cycle of the frame body; optionally poke load_valid while busy.
    task automatic stream(input bit sel, input logic [7:0] seq, input logic par,
                          input int intrude, input string tag);
        int   dv;
        int   k;
        logic e;
        logic [3:0] o;
        dv = sel ? 1 : 4;
        for (int c = 1; c <= NB * dv; c++) begin
            k = (c - 1) / dv;
            e = (k < 8) ? seq[7 - k] : par;
            o = outs(sel);
            if (intrude > 0 && c == intrude) begin
                drive(sel, 1'b1, 8'h00);
                chk(tag, "ready_while_busy", {7'd0, o[3]}, 8'd0);
            end
            if (intrude > 0 && c == intrude + 1) drive(sel, 1'b0, 8'h00);
            chk(tag, $sformatf("s_out c%0d", c), {7'd0, o[2]}, {7'd0, e});
            chk(tag, $sformatf("busy c%0d", c),  {7'd0, o[1]}, 8'd1);
            chk(tag, $sformatf("done c%0d", c),  {7'd0, o[0]}, 8'd0);
            tick();
        end
    endtask

    // Done cycle checks; optionally chain the next word in this same cycle.
    task automatic finish_frame(input bit sel, input string tag, input bit chain, input logic [7:0] nw);
        logic [3:0] o;
        o = outs(sel);
        chk(tag, "done_pulse", {7'd0, o[0]}, 8'd1);
        chk(tag, "busy_at_done", {7'd0, o[1]}, 8'd0);
        chk(tag, "s_out_at_done", {7'd0, o[2]}, 8'd0);
        chk(tag, "ready_at_done", {7'd0, o[3]}, 8'd1);
        if (chain) begin
            drive(sel, 1'b1, nw);
            tick();
            drive(sel, 1'b0, ~nw);
        end else begin
            tick();
            o = outs(sel);
            chk(tag, "done_cleared", {7'd0, o[0]}, 8'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] o;

        tbl[0] = '{1'b0, 8'hA5, 8'hA5, 1'b0, "a_A5"};
        tbl[1] = '{1'b0, 8'h07, 8'h07, 1'b1, "a_07"};
        tbl[2] = '{1'b0, 8'h3C, 8'h3C, 1'b0, "a_3C"};
        tbl[3] = '{1'b1, 8'h0F, 8'hF0, 1'b0, "b_0F"};
        tbl[4] = '{1'b1, 8'h01, 8'h80, 1'b1, "b_01"};
        tbl[5] = '{1'b1, 8'hB2, 8'h4D, 1'b0, "b_B2"};

        // Reset held for 3 cycles, then released.
        repeat (3) tick();
        for (int s = 0; s < 2; s++) begin
            o = outs(s[0]);
            chk("reset", "s_out", {7'd0, o[2]}, 8'd0);
            chk("reset", "busy",  {7'd0, o[1]}, 8'd0);
            chk("reset", "done",  {7'd0, o[0]}, 8'd0);
        end
        reset = 1'b1;
        tick();
        for (int s = 0; s < 2; s++) begin
            o = outs(s[0]);
            chk("post_reset", "load_ready", {7'd0, o[3]}, 8'd1);
            chk("post_reset", "busy", {7'd0, o[1]}, 8'd0);
        end

        // Table of single frames.
        for (int i = 0; i < 6; i++) begin
            start(tbl[i].sel, tbl[i].word);
            stream(tbl[i].sel, tbl[i].seq, tbl[i].par, 0, tbl[i].tag);
            finish_frame(tbl[i].sel, tbl[i].tag, 1'b0, 8'h00);
        end

        // Load while busy is ignored; then a word chained into the done cycle.
        start(1'b0, 8'hFF);
        stream(1'b0, 8'hFF, 1'b0, 10, "b2b_FF");
        finish_frame(1'b0, "b2b_FF", 1'b1, 8'h81);
        stream(1'b0, 8'h81, 1'b0, 0, "b2b_81");
        finish_frame(1'b0, "b2b_81", 1'b0, 8'h00);

        // Reset in the middle of a frame: cycle 14 of an A5 frame.
        start(1'b0, 8'hA5);
        for (int c = 1; c <= 13; c++) begin
            o = outs(1'b0);
            chk("midrst", $sformatf("s_out c%0d", c), {7'd0, o[2]}, {7'd0, tbl[0].seq[7 - (c - 1) / 4]});
            tick();
        end
        reset = 1'b0;
        #1;
        o = outs(1'b0);
        chk("midrst", "s_out_async", {7'd0, o[2]}, 8'd0);
        chk("midrst", "busy_async",  {7'd0, o[1]}, 8'd0);
        chk("midrst", "done_async",  {7'd0, o[0]}, 8'd0);
        tick();
        reset = 1'b1;
        for (int c = 0; c < 24; c++) begin
            o = outs(1'b0);
            chk("midrst", $sformatf("no_done c%0d", c), {7'd0, o[0]}, 8'd0);
            chk("midrst", $sformatf("ready c%0d", c), {7'd0, o[3]}, 8'd1);
            tick();
        end
        start(1'b0, 8'h3C);
        stream(1'b0, 8'h3C, 1'b0, 0, "after_rst_3C");
        finish_frame(1'b0, "after_rst_3C", 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in, serial-out shift transmitter; the sending end of the team's serial shift-register link.
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Shifts the word out on s_out, one bit per DIV clock cycles, using an internal clock-enable divider (no derived clocks).
- Pulses done when the frame completes; feeds the existing serial-in shift-register receive path.

Parameters:
- WIDTH, 8, data word width in bits (>= 2).
- DIV, 4, clk cycles per serial bit (>= 1); sets the bit rate.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = bit 0 first.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- data_in  input  WIDTH  parallel word to transmit.
- load_valid  input  1  data_in is valid.
- load_ready  output  1  block can accept a word.
- s_out  output  1  serial data out.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, shift register=0, divider=0, bit counter=0.
  - s_out=0, busy=0, done=0; load_ready=1 once reset deasserts.
- States: IDLE, SHIFT (PARITY added by the optional feature).
- load_ready = (state==IDLE), combinational from the state register.
- IDLE:
  - s_out=0.
  - On a clk edge with load_valid=1, capture data_in into the shift register; divider=0, bit counter=0; go to SHIFT.
  - load_valid=0: remain in IDLE.
- SHIFT:
  - s_out is driven from a register: the current bit (MSB when MSB_FIRST=1, else LSB). It changes only at bit boundaries.
  - The first bit appears on s_out in the cycle after the accept edge.
  - Divider counts 0..DIV-1 and increments every cycle.
  - At DIV-1: divider wraps to 0, the register shifts by one, and the bit counter increments.
  - When the bit counter reaches WIDTH-1 and the divider reaches DIV-1, go to IDLE. The same edge sets done=1 for exactly one cycle.
- Timing:
  - Each bit is held exactly DIV cycles; a frame occupies WIDTH*DIV cycles of busy.
  - done is high in the first IDLE cycle.
  - With DIV=1, bits change every cycle.
- busy = (state!=IDLE), registered, so it matches the state.
- Back-to-back: load_valid may be high in the done cycle. That word is accepted at that edge, and its first bit follows with no gap beyond the single IDLE cycle.
- load_valid while busy: ignored; no capture; data_in is don't-care.
- data_in changing during SHIFT has no effect on the frame.
- Reset mid-frame: immediate abort to reset values; no done pulse; the partial frame is discarded.
- Divider and bit counter widths: clog2 of DIV and WIDTH (minimum 1 bit). They never exceed DIV-1 or WIDTH-1.

Optional Feature:
- Macro: PISO_TX_PARITY_EN.
- When defined:
  - After the last data bit, state PARITY drives one extra bit for DIV cycles.
  - The extra bit is the even-parity bit: XOR of the captured word.
  - Frame length becomes (WIDTH+1)*DIV cycles; done pulses after the parity bit.
  - Parity is computed from the word captured at accept, not from data_in.
- When undefined: no PARITY state, no parity logic; frame is WIDTH*DIV cycles, as above.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, then release -> s_out=0, busy=0, done=0, load_ready=1; reset=0 asynchronously forces these values within the same cycle.
- Basic frame: WIDTH=8, DIV=4, MSB_FIRST=1; load 8'hA5 at cycle 0 -> s_out = 1,0,1,0,0,1,0,1, each for 4 cycles, over cycles 1-32; done=1 only at cycle 33; busy=1 over cycles 1-32.
- LSB-first and DIV=1: MSB_FIRST=0, DIV=1; load 8'h0F -> s_out 1,1,1,1,0,0,0,0 on consecutive cycles; done 9 cycles after accept.
- Busy and back-to-back:
  - load 8'hFF, then pulse load_valid with 8'h00 during cycle 10 -> second word ignored; s_out=1 for 32 cycles.
  - Hold load_valid with 8'h81 during the done cycle -> accepted; s_out = 1,0,0,0,0,0,0,1 starting the next cycle.
- Reset mid-frame: load 8'hA5; assert reset=0 at cycle 14 -> s_out=0, busy=0 immediately; no done pulse. After release, load_ready=1 and a new 8'h3C frame is transmitted correctly.
- Parity (PISO_TX_PARITY_EN defined):
  - 8'hA5 -> 9th bit 0, done at cycle 37.
  - 8'h07 -> 9th bit 1.
  - Without the macro: 8'h07 -> done at cycle 33, no extra bit.
